// File: rtl/card_tran_processor.sv
// Card-side payment responder: per-card credit table, timed charge authorization
// with one-cycle VALID_TRAN / DECLINED result pulses, and saturating credit top-ups.
module card_tran_processor #(
    parameter int NUM_CARDS   = 16,
    parameter int ID_W        = 4,
    parameter int BAL_W       = 8,
    parameter int INIT_BAL    = 10,
    parameter int AUTH_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CARD_IN,
    input  logic [ID_W-1:0]  CARD_ID,
    input  logic             CHARGE_REQ,
    input  logic [2:0]       COST,
    input  logic             TOPUP,
    input  logic [ID_W-1:0]  TOPUP_ID,
    input  logic [BAL_W-1:0] TOPUP_AMT,
    output logic             VALID_TRAN,
    output logic             DECLINED,
    output logic             BUSY,
    output logic [BAL_W-1:0] BALANCE
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        AUTH,
        RESULT,
        WAIT_REMOVE
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  card_id_q;
    logic [2:0]       cost_q;
    logic [2:0]       cnt_q;
    logic             valid_tran_q;
    logic             declined_q;
    logic [BAL_W-1:0] bal_tab [NUM_CARDS];

    logic [BAL_W-1:0] cur_bal;
    logic [BAL_W-1:0] cost_ext;
    logic             auth_ok;

    function automatic logic in_range(input logic [ID_W-1:0] id);
        return 32'(id) < 32'(NUM_CARDS);
    endfunction

    function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                                 input logic [BAL_W-1:0] b);
        logic [BAL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[BAL_W] ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
    endfunction

    // Unknown cards read as an empty balance so only free items are granted.
    always_comb begin
        cur_bal = '0;
        if (in_range(card_id_q)) begin
            cur_bal = bal_tab[card_id_q];
        end
    end

    assign cost_ext   = BAL_W'(cost_q);
    assign auth_ok    = (cur_bal >= cost_ext);

    assign VALID_TRAN = valid_tran_q;
    assign DECLINED   = declined_q;
    assign BUSY       = (state != IDLE);
    assign BALANCE    = (state == IDLE) ? '0 : cur_bal;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            card_id_q    <= '0;
            cost_q       <= '0;
            cnt_q        <= '0;
            valid_tran_q <= 1'b0;
            declined_q   <= 1'b0;
            for (int i = 0; i < NUM_CARDS; i++) begin
                bal_tab[i] <= BAL_W'(INIT_BAL);
            end
        end else begin
            valid_tran_q <= 1'b0;
            declined_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (CARD_IN) begin
                        state     <= WAIT_REQ;
                        card_id_q <= CARD_ID;
                    end else if (TOPUP && in_range(TOPUP_ID)) begin
                        bal_tab[TOPUP_ID] <= sat_add(bal_tab[TOPUP_ID], TOPUP_AMT);
                    end
                end
                WAIT_REQ: begin
                    if (!CARD_IN) begin
                        state <= IDLE;
                    end else if (CHARGE_REQ) begin
                        state  <= AUTH;
                        cost_q <= COST;
                        cnt_q  <= 3'(AUTH_CYCLES - 1);
                    end
                end
                AUTH: begin
                    if (!CARD_IN) begin
                        state <= IDLE;
                    end else if (cnt_q == '0) begin
                        // Decision is registered here so the pulse is high during RESULT.
                        state        <= RESULT;
                        valid_tran_q <= auth_ok;
                        declined_q   <= !auth_ok;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESULT: begin
                    state <= WAIT_REMOVE;
                    if (valid_tran_q && in_range(card_id_q)) begin
                        bal_tab[card_id_q] <= cur_bal - cost_ext;
                    end
                end
                WAIT_REMOVE: begin
                    if (!CARD_IN) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_tran_processor.sv
// Directed and randomized bench for card_tran_processor against a per-card
// balance array model updated at transaction level.
module tb_card_tran_processor;

    localparam int NUM_CARDS   = 16;
    localparam int INIT_BAL    = 10;
    localparam int AUTH_CYCLES = 2;
    localparam int BAL_MAX     = 255;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CARD_IN;
    logic [3:0] CARD_ID;
    logic       CHARGE_REQ;
    logic [2:0] COST;
    logic       TOPUP;
    logic [3:0] TOPUP_ID;
    logic [7:0] TOPUP_AMT;
    logic       VALID_TRAN;
    logic       DECLINED;
    logic       BUSY;
    logic [7:0] BALANCE;

    int checks = 0;
    int errors = 0;
    int model_bal [NUM_CARDS];

    always #5 CLK = ~CLK;

    card_tran_processor dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CARD_IN    (CARD_IN),
        .CARD_ID    (CARD_ID),
        .CHARGE_REQ (CHARGE_REQ),
        .COST       (COST),
        .TOPUP      (TOPUP),
        .TOPUP_ID   (TOPUP_ID),
        .TOPUP_AMT  (TOPUP_AMT),
        .VALID_TRAN (VALID_TRAN),
        .DECLINED   (DECLINED),
        .BUSY       (BUSY),
        .BALANCE    (BALANCE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CARDS; i++) model_bal[i] = INIT_BAL;
    endtask

    task automatic peek(input int id);
        CARD_IN = 1'b1;
        CARD_ID = 4'(id);
        tick();
        chk("peek_busy", 32'(BUSY), 1);
        chk("peek_bal", 32'(BALANCE), model_bal[id]);
        CARD_IN = 1'b0;
        tick();
        chk("peek_idle", 32'(BUSY), 0);
    endtask

    task automatic charge(input int id, input int cost, input bit second_req);
        int  vmask;
        int  dmask;
        bit  ok;
        vmask = 0;
        dmask = 0;
        ok    = (cost <= model_bal[id]);
        CARD_IN = 1'b1;
        CARD_ID = 4'(id);
        tick();
        chk("ins_bal", 32'(BALANCE), model_bal[id]);
        CHARGE_REQ = 1'b1;
        COST       = 3'(cost);
        tick();
        CHARGE_REQ = 1'b0;
        COST       = 3'($urandom);
        for (int j = 1; j <= AUTH_CYCLES + 2; j++) begin
            tick();
            if (VALID_TRAN === 1'b1) vmask |= (1 << j);
            if (DECLINED === 1'b1) dmask |= (1 << j);
        end
        if (ok) model_bal[id] -= cost;
        chk("valid_mask", vmask, ok ? (1 << AUTH_CYCLES) : 0);
        chk("decl_mask", dmask, ok ? 0 : (1 << AUTH_CYCLES));
        chk("post_bal", 32'(BALANCE), model_bal[id]);
        if (second_req) begin
            vmask = 0;
            CHARGE_REQ = 1'b1;
            COST       = 3'd1;
            tick();
            CHARGE_REQ = 1'b0;
            for (int j = 1; j <= AUTH_CYCLES + 2; j++) begin
                tick();
                if (VALID_TRAN !== 1'b0 || DECLINED !== 1'b0) vmask |= (1 << j);
            end
            chk("second_req_pulse", vmask, 0);
            chk("second_req_bal", 32'(BALANCE), model_bal[id]);
        end
        CARD_IN = 1'b0;
        tick();
        chk("rm_busy", 32'(BUSY), 0);
        chk("rm_bal", 32'(BALANCE), 0);
    endtask

    task automatic abort_charge(input int id, input int cost);
        int pmask;
        pmask = 0;
        CARD_IN = 1'b1;
        CARD_ID = 4'(id);
        tick();
        CHARGE_REQ = 1'b1;
        COST       = 3'(cost);
        tick();
        CHARGE_REQ = 1'b0;
        CARD_IN    = 1'b0;
        tick();
        chk("abort_busy", 32'(BUSY), 0);
        for (int j = 1; j <= AUTH_CYCLES + 2; j++) begin
            tick();
            if (VALID_TRAN !== 1'b0 || DECLINED !== 1'b0) pmask |= (1 << j);
        end
        chk("abort_pulse", pmask, 0);
        peek(id);
    endtask

    task automatic topup(input int id, input int amt, input bit with_card);
        TOPUP     = 1'b1;
        TOPUP_ID  = 4'(id);
        TOPUP_AMT = 8'(amt);
        CARD_IN   = with_card;
        CARD_ID   = 4'(id);
        tick();
        TOPUP = 1'b0;
        if (!with_card) begin
            model_bal[id] = (model_bal[id] + amt > BAL_MAX) ? BAL_MAX : model_bal[id] + amt;
        end else begin
            chk("tu_drop_busy", 32'(BUSY), 1);
            chk("tu_drop_bal", 32'(BALANCE), model_bal[id]);
            CARD_IN = 1'b0;
            tick();
        end
    endtask

    initial begin
        int pmask;
        RESET      = 1'b0;
        CARD_IN    = 1'b0;
        CARD_ID    = '0;
        CHARGE_REQ = 1'b0;
        COST       = '0;
        TOPUP      = 1'b0;
        TOPUP_ID   = '0;
        TOPUP_AMT  = '0;
        model_reset();

        // T1 reset
        repeat (5) tick();
        chk("rst_valid", 32'(VALID_TRAN), 0);
        chk("rst_decl", 32'(DECLINED), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_bal", 32'(BALANCE), 0);
        RESET = 1'b1;
        tick();
        peek(3);

        // T2 good charge
        charge(1, 3, 1'b0);
        chk("t2_bal7", model_bal[1], 7);

        // T3 drain and decline
        repeat (4) charge(2, 2, 1'b0);
        charge(2, 5, 1'b0);
        peek(2);

        // T4 abort mid-AUTH
        abort_charge(6, 3);

        // T5 saturating top-up and dropped top-up
        topup(4, 245, 1'b0);
        topup(4, 20, 1'b0);
        peek(4);
        topup(4, 7, 1'b1);
        topup(9, 100, 1'b1);
        peek(9);
        charge(4, 0, 1'b1);
        charge(7, 6, 1'b1);

        // T6 async reset mid-AUTH
        topup(5, 50, 1'b0);
        peek(5);
        CARD_IN = 1'b1;
        CARD_ID = 4'd5;
        tick();
        CHARGE_REQ = 1'b1;
        COST       = 3'd3;
        tick();
        CHARGE_REQ = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_valid", 32'(VALID_TRAN), 0);
        chk("arst_decl", 32'(DECLINED), 0);
        chk("arst_busy", 32'(BUSY), 0);
        chk("arst_bal", 32'(BALANCE), 0);
        CARD_IN = 1'b0;
        model_reset();
        pmask = 0;
        for (int j = 0; j < AUTH_CYCLES + 2; j++) begin
            tick();
            if (VALID_TRAN !== 1'b0 || DECLINED !== 1'b0) pmask |= (1 << j);
        end
        chk("arst_pulse", pmask, 0);
        RESET = 1'b1;
        tick();
        peek(5);
        peek(4);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0, 1: charge($urandom_range(0, NUM_CARDS - 1), $urandom_range(0, 7), 1'($urandom));
                2:    topup($urandom_range(0, NUM_CARDS - 1), $urandom_range(0, 255), 1'b0);
                3:    topup($urandom_range(0, NUM_CARDS - 1), $urandom_range(1, 255), 1'b1);
                default: abort_charge($urandom_range(0, NUM_CARDS - 1), $urandom_range(0, 7));
            endcase
        end
        for (int i = 0; i < NUM_CARDS; i++) peek(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
